// File: rtl/regfile_pkg.sv
// Shared register-file types, used by the writeback arbiter, the scoreboard,
// the register file and the issue logic.
package regfile_pkg;
    localparam int NUM_REGS   = 8;
    localparam int REG_ADDR_W = 3;
    localparam int DATA_W     = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at commit.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set,
    input  reg_addr_t           set_addr,
    input  logic                clr,
    input  reg_addr_t           clr_addr,
    output logic [NUM_REGS-1:0] pending
);
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] pending_next;

    // Set is OR-ed in after the clear so a newer producer keeps its bit.
    always_comb begin
        set_mask     = '0;
        clr_mask     = '0;
        set_mask[set_addr] = set;
        clr_mask[clr_addr] = clr;
        pending_next = (pending & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_next;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter (ALU vs load unit) with starvation guard,
// registered write port and pending-write scoreboard.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    input  reg_addr_t           alu_rd,
    input  reg_data_t           alu_data,
    output logic                alu_ready,
    input  logic                mem_valid,
    input  reg_addr_t           mem_rd,
    input  reg_data_t           mem_data,
    output logic                mem_ready,
    input  logic                issue_set,
    input  reg_addr_t           issue_rd,
    output reg_addr_t           rf_rc,
    output logic                rf_write_enable,
    output reg_data_t           rf_write_data,
    output logic [NUM_REGS-1:0] sb_pending
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_next;
    logic             alu_prio;

    // Mem wins ties unless the ALU has lost STARVE_LIMIT cycles in a row.
    always_comb begin
        alu_prio    = (starve_cnt == LIMIT);
        alu_ready   = alu_valid && (!mem_valid || alu_prio);
        mem_ready   = mem_valid && !(alu_valid && alu_prio);
        starve_next = starve_cnt;
        if (!alu_valid || alu_ready) starve_next = '0;
        else if (starve_cnt != LIMIT) starve_next = starve_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_cnt <= '0;
        else        starve_cnt <= starve_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write_enable <= 1'b0;
            rf_rc           <= '0;
            rf_write_data   <= '0;
        end else begin
            rf_write_enable <= alu_ready || mem_ready;
            if (mem_ready) begin
                rf_rc         <= mem_rd;
                rf_write_data <= mem_data;
            end else if (alu_ready) begin
                rf_rc         <= alu_rd;
                rf_write_data <= alu_data;
            end
        end
    end

    regfile_scoreboard u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set      (issue_set),
        .set_addr (issue_rd),
        .clr      (rf_write_enable),
        .clr_addr (rf_rc),
        .pending  (sb_pending)
    );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration, starvation, scoreboard, async reset.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, mem_valid, issue_set;
    reg_addr_t   alu_rd, mem_rd, issue_rd, rf_rc;
    reg_data_t   alu_data, mem_data, rf_write_data;
    logic        alu_ready, mem_ready, rf_write_enable;
    logic [7:0]  sb_pending;

    int passed = 0;
    int total  = 0;

    regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .issue_set(issue_set), .issue_rd(issue_rd),
        .rf_rc(rf_rc), .rf_write_enable(rf_write_enable), .rf_write_data(rf_write_data),
        .sb_pending(sb_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        mem_valid = 0; mem_rd = '0; mem_data = '0;
        issue_set = 0; issue_rd = '0;
        #2;
        chk("rst_we",   32'(rf_write_enable), 32'd0);
        chk("rst_rc",   32'(rf_rc),           32'd0);
        chk("rst_data", rf_write_data,        32'd0);
        chk("rst_sb",   32'(sb_pending),      32'h00);
        chk("rst_cnt",  32'(dut.starve_cnt),  32'd0);
        chk("rst_rdy",  32'({alu_ready, mem_ready}), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Single ALU requester
        tick();
        alu_valid = 1; alu_rd = 3'd5; alu_data = 32'hDEADBEEF;
        #1;
        chk("single_alu_rdy", 32'(alu_ready), 32'd1);
        chk("single_mem_rdy", 32'(mem_ready), 32'd0);
        tick();
        alu_valid = 0;
        chk("single_we",   32'(rf_write_enable), 32'd1);
        chk("single_rc",   32'(rf_rc),           32'd5);
        chk("single_data", rf_write_data,        32'hDEADBEEF);
        tick();
        chk("single_we_off", 32'(rf_write_enable), 32'd0);

        // Contention: mem first, then alu
        alu_valid = 1; alu_rd = 3'd2; alu_data = 32'h22;
        mem_valid = 1; mem_rd = 3'd3; mem_data = 32'h33;
        #1;
        chk("cont_mem_rdy", 32'(mem_ready), 32'd1);
        chk("cont_alu_rdy", 32'(alu_ready), 32'd0);
        tick();
        mem_valid = 0;
        chk("cont_rc0",   32'(rf_rc), 32'd3);
        chk("cont_data0", rf_write_data, 32'h33);
        #1;
        chk("cont_alu_rdy2", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 0;
        chk("cont_rc1", 32'(rf_rc), 32'd2);
        chk("cont_we1", 32'(rf_write_enable), 32'd1);
        tick();
        chk("cont_we_off", 32'(rf_write_enable), 32'd0);

        // Starvation: mem held 10 cycles, alu held until granted
        mem_valid = 1; mem_rd = 3'd0; mem_data = 32'h0;
        alu_valid = 1; alu_rd = 3'd1; alu_data = 32'hA;
        for (int c = 1; c <= 10; c++) begin
            if (c == 6) alu_valid = 0;
            #1;
            chk($sformatf("starve_alu_c%0d", c), 32'(alu_ready), 32'(c == 5));
            chk($sformatf("starve_mem_c%0d", c), 32'(mem_ready), 32'(c != 5));
            if (c == 5) chk("starve_cnt_lim", 32'(dut.starve_cnt), 32'd4);
            if (c == 6) chk("starve_cnt_clr", 32'(dut.starve_cnt), 32'd0);
            tick();
        end
        mem_valid = 0;
        tick();
        tick();
        chk("starve_drain_we", 32'(rf_write_enable), 32'd0);

        // Scoreboard: issue rd7 at cycle 0, mem grant rd7 at cycle 3
        issue_set = 1; issue_rd = 3'd7;
        tick();
        issue_set = 0;
        chk("sb_set7", 32'(sb_pending), 32'h80);
        tick();
        tick();
        mem_valid = 1; mem_rd = 3'd7; mem_data = 32'h77;
        tick();
        mem_valid = 0;
        chk("sb_commit_rc", 32'(rf_rc), 32'd7);
        chk("sb_still7",    32'(sb_pending), 32'h80);
        tick();
        chk("sb_clr7", 32'(sb_pending), 32'h00);

        // Collision on the same register: set wins
        issue_set = 1; issue_rd = 3'd4;
        tick();
        issue_set = 0;
        chk("col_set4", 32'(sb_pending), 32'h10);
        mem_valid = 1; mem_rd = 3'd4; mem_data = 32'h44;
        tick();
        mem_valid = 0;
        issue_set = 1; issue_rd = 3'd4;
        tick();
        issue_set = 0;
        chk("col_keep4", 32'(sb_pending), 32'h10);
        alu_valid = 1; alu_rd = 3'd4; alu_data = 32'h45;
        tick();
        alu_valid = 0;
        tick();
        chk("col_clr4", 32'(sb_pending), 32'h00);

        // Different registers: commit rd1, issue rd6
        issue_set = 1; issue_rd = 3'd1;
        tick();
        issue_set = 0;
        chk("diff_set1", 32'(sb_pending), 32'h02);
        mem_valid = 1; mem_rd = 3'd1; mem_data = 32'h11;
        tick();
        mem_valid = 0;
        issue_set = 1; issue_rd = 3'd6;
        tick();
        issue_set = 0;
        chk("diff_1clr_6set", 32'(sb_pending), 32'h40);
        mem_valid = 1; mem_rd = 3'd6; mem_data = 32'h66;
        tick();
        mem_valid = 0;
        tick();
        chk("diff_clr6", 32'(sb_pending), 32'h00);

        // Async reset with a write in flight and sb=0F
        for (int r = 0; r < 4; r++) begin
            issue_set = 1; issue_rd = reg_addr_t'(r);
            if (r == 3) begin
                alu_valid = 1; alu_rd = 3'd5; alu_data = 32'h55;
            end
            tick();
        end
        issue_set = 0; alu_valid = 0;
        chk("ar_pre_we", 32'(rf_write_enable), 32'd1);
        chk("ar_pre_sb", 32'(sb_pending), 32'h0F);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_we",  32'(rf_write_enable), 32'd0);
        chk("ar_sb",  32'(sb_pending),      32'h00);
        chk("ar_rc",  32'(rf_rc),           32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("ar_post_we0", 32'(rf_write_enable), 32'd0);
        tick();
        chk("ar_post_we1", 32'(rf_write_enable), 32'd0);
        chk("ar_post_sb",  32'(sb_pending),      32'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and pending-write scoreboard for the 8×32 register file. Two writeback sources compete for the single register-file write port: the ALU and the load unit. The block picks one per cycle, registers the winning write onto the port, and keeps an 8-bit scoreboard. Issue logic reads the scoreboard to stall on read-after-write hazards.

## Interface
- STARVE_LIMIT, 4: consecutive cycles the ALU may lose arbitration before it is granted priority.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  3  ALU destination register.
- alu_data  in  32  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- mem_valid  in  1  load-unit writeback request.
- mem_rd  in  3  load destination register.
- mem_data  in  32  load result.
- mem_ready  out  1  load request accepted this cycle.
- issue_set  in  1  an instruction that writes a register has issued.
- issue_rd  in  3  destination register of the issued instruction.
- rf_rc  out  3  register-file write address.
- rf_write_enable  out  1  register-file write strobe.
- rf_write_data  out  32  register-file write data.
- sb_pending  out  8  bit i = 1 means a write to register i is outstanding.

## Operation
- A request transfers when valid && ready. Ready is combinational from valid and the arbitration state. Ready never depends on the other source's ready.
- Priority:
  - Default: mem wins when both sources are valid.
  - If starve_cnt == STARVE_LIMIT, alu wins instead.
- Only one ready is asserted per cycle. A lone valid requester is always granted; there is no backpressure from the register file.
- starve_cnt:
  - Increments when alu_valid is high and alu loses.
  - Clears when alu is granted or alu_valid is low.
  - Saturates at STARVE_LIMIT.
  - Width is clog2(STARVE_LIMIT+1).
- Granted rd and data are registered into rf_rc and rf_write_data. rf_write_enable is registered high for exactly one cycle per grant.
- Scoreboard:
  - issue_set sets bit issue_rd.
  - A registered commit (rf_write_enable high) clears bit rf_rc.
  - Set and clear on the same register in the same cycle: set wins, because a newer producer is now outstanding.
  - Set and clear on different registers both take effect.
- Register 0 is an ordinary register; there is no hard-wired zero.
- Writes with no matching pending bit commit normally and leave the scoreboard unchanged.
- Valid must stay asserted with stable rd/data until ready. The block does not check this.

## Timing
- Reset values:
  - rf_write_enable=0, rf_rc=0, rf_write_data=0.
  - sb_pending=8'h00, starve_cnt=0.
  - alu_ready/mem_ready follow the combinational rule from reset state.
- Latency:
  - A grant in cycle N gives rf_write_enable=1 in cycle N+1.
  - The register file captures the data at the N+2 edge.
  - sb_pending clears one cycle after the commit edge.
- Back-to-back grants give a continuous rf_write_enable with one write per cycle. Throughput is 1 write/cycle.
- An issue in cycle N shows in sb_pending in cycle N+1.
- Reset asserted mid-operation:
  - Any in-flight registered write is dropped (rf_write_enable forced to 0).
  - The scoreboard and counter clear asynchronously.
  - Upstream requesters are expected to be reset too.
- Starvation bound: with mem_valid held high continuously, alu waits at most STARVE_LIMIT cycles.

## Structure
- Shared package regfile_pkg:
  - NUM_REGS=8, REG_ADDR_W=3, DATA_W=32.
  - typedef reg_addr_t (logic [REG_ADDR_W-1:0]).
  - typedef reg_data_t (logic [DATA_W-1:0]).
  - Shared with the register file and issue logic.
- One sub-module, regfile_scoreboard:
  - Inputs: set, set_addr, clr, clr_addr.
  - Output: pending vector.
  - Implements the set-wins rule.
- The arbiter FSM is the starve counter. There is no other state.

## Test plan
- Single requester: alu_valid=1, rd=5, data=32'hDEADBEEF for one cycle. Required: alu_ready=1 same cycle; next cycle rf_write_enable=1, rf_rc=5, rf_write_data=32'hDEADBEEF; then rf_write_enable=0.
- Contention: both valid, alu rd=2, mem rd=3. Required: mem granted first; alu granted the following cycle; rf_rc sequence is 3 then 2.
- Starvation: mem_valid held 10 cycles, alu_valid held, STARVE_LIMIT=4. Required: alu_ready rises in the 5th cycle; mem resumes winning the next cycle; starve_cnt returns to 0.
- Scoreboard: issue_set rd=7 at cycle 0. Required: sb_pending=8'h80 at cycle 1. After a mem grant with rd=7 at cycle 3: bit 7 clears at cycle 5.
- Set/clear collision: the commit of rd=4 coincides with issue_set rd=4. Required: bit 4 stays 1. In a separate check, commit rd=1 with issue rd=6 gives bit 1 = 0 and bit 6 = 1.
- Async reset: assert rst_n=0 mid-cycle while rf_write_enable=1 and sb_pending=8'h0F. Required: immediately rf_write_enable=0 and sb_pending=0; no write occurs after release.
